// File: rtl/aes_host_ctrl.sv
// aes_host_ctrl: register-bus initiator that runs one aes block per request.
// Each phase starts with one cs=0 cycle: 8 such cycles with a key load, 5 without.
module aes_host_ctrl #(
    parameter int POLL_TIMEOUT = 4096,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [127:0]      req_key,
    input  logic [127:0]      req_block,
    input  logic              req_encdec,
    input  logic              req_new_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [127:0]      rsp_data,
    output logic              rsp_error,
    output logic              busy,
    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_KEY, S_INIT, S_PINIT,
        S_BLK, S_NEXT, S_PVAL, S_RES, S_RSP
    } state_t;

    state_t         state, state_d, nxt;
    logic           gap, gap_d;
    logic [2:0]     idx, idx_d;
    logic [PW-1:0]  pcnt, pcnt_d;
    logic [127:0]   key_q, blk_q, cached_key;
    logic           encdec_q, new_key_q, key_cached;
    logic           need_key, adv;
    logic           accept, cache_set, err_set, res_wr;
    logic [7:0]     addr8;
    logic [31:0]    key_word, blk_word;
    logic           poll_last;

    assign need_key  = new_key_q || !key_cached || (key_q != cached_key);
    assign key_word  = idx[2] ? 32'd0 : key_q[{idx[1:0], 5'd0} +: 32];
    assign blk_word  = blk_q[{idx[1:0], 5'd0} +: 32];
    assign poll_last = (pcnt == PW'(POLL_TIMEOUT - 1));
    assign address   = ADDR_W'(addr8);

    always_comb begin
        state_d    = state;
        gap_d      = 1'b0;
        idx_d      = idx;
        pcnt_d     = pcnt;
        nxt        = state;
        adv        = 1'b0;
        cs         = 1'b0;
        we         = 1'b0;
        addr8      = 8'h00;
        write_data = 32'd0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state != S_IDLE);
        accept     = 1'b0;
        cache_set  = 1'b0;
        err_set    = 1'b0;
        res_wr     = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    adv    = 1'b1;
                    nxt    = S_CFG;
                end
            end
            S_CFG: if (!gap) begin
                cs         = 1'b1;
                we         = 1'b1;
                addr8      = 8'h0a;
                write_data = {30'd0, 1'b0, encdec_q};
                adv        = 1'b1;
                nxt        = need_key ? S_KEY : S_BLK;
            end
            S_KEY: if (!gap) begin
                cs         = 1'b1;
                we         = 1'b1;
                addr8      = 8'h10 + {5'd0, idx};
                write_data = key_word;
                idx_d      = idx + 3'd1;
                adv        = (idx == 3'd7);
                nxt        = S_INIT;
            end
            S_INIT: if (!gap) begin
                cs         = 1'b1;
                we         = 1'b1;
                addr8      = 8'h08;
                write_data = 32'h1;
                adv        = 1'b1;
                nxt        = S_PINIT;
            end
            S_PINIT: if (!gap) begin
                cs    = 1'b1;
                addr8 = 8'h09;
                if (read_data[0]) begin
                    cache_set = 1'b1;
                    adv       = 1'b1;
                    nxt       = S_BLK;
                end else if (poll_last) begin
                    err_set = 1'b1;
                    adv     = 1'b1;
                    nxt     = S_RSP;
                end else begin
                    pcnt_d = pcnt + PW'(1);
                end
            end
            S_BLK: if (!gap) begin
                cs         = 1'b1;
                we         = 1'b1;
                addr8      = 8'h20 + {5'd0, idx};
                write_data = blk_word;
                idx_d      = idx + 3'd1;
                adv        = (idx == 3'd3);
                nxt        = S_NEXT;
            end
            S_NEXT: if (!gap) begin
                cs         = 1'b1;
                we         = 1'b1;
                addr8      = 8'h08;
                write_data = 32'h2;
                adv        = 1'b1;
                nxt        = S_PVAL;
            end
            S_PVAL: if (!gap) begin
                cs    = 1'b1;
                addr8 = 8'h09;
                if (read_data[1]) begin
                    adv = 1'b1;
                    nxt = S_RES;
                end else if (poll_last) begin
                    err_set = 1'b1;
                    adv     = 1'b1;
                    nxt     = S_RSP;
                end else begin
                    pcnt_d = pcnt + PW'(1);
                end
            end
            S_RES: if (!gap) begin
                cs     = 1'b1;
                addr8  = 8'h30 + {5'd0, idx};
                res_wr = 1'b1;
                idx_d  = idx + 3'd1;
                adv    = (idx == 3'd3);
                nxt    = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    adv = 1'b1;
                    nxt = S_IDLE;
                end
            end
            default: begin
                adv = 1'b1;
                nxt = S_IDLE;
            end
        endcase
        // every bus phase opens with an idle cycle so cs drops between phases
        if (adv) begin
            state_d = nxt;
            gap_d   = (nxt != S_RSP) && (nxt != S_IDLE);
            idx_d   = 3'd0;
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            gap        <= 1'b0;
            idx        <= 3'd0;
            pcnt       <= '0;
            key_q      <= '0;
            blk_q      <= '0;
            encdec_q   <= 1'b0;
            new_key_q  <= 1'b0;
            key_cached <= 1'b0;
            cached_key <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
        end else begin
            state <= state_d;
            gap   <= gap_d;
            idx   <= idx_d;
            pcnt  <= pcnt_d;
            if (accept) begin
                key_q     <= req_key;
                blk_q     <= req_block;
                encdec_q  <= req_encdec;
                new_key_q <= req_new_key;
                rsp_error <= 1'b0;
            end
            if (cache_set) begin
                key_cached <= 1'b1;
                cached_key <= key_q;
            end
            if (res_wr) begin
                rsp_data[{idx[1:0], 5'd0} +: 32] <= read_data;
            end
            if (err_set) begin
                rsp_error  <= 1'b1;
                rsp_data   <= '0;
                key_cached <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// tb_aes_host_ctrl: drives requests into aes_host_ctrl against a register-slave
// stand-in for the aes core and checks bus traces, results and handshakes.
module tb_aes_host_ctrl;

    localparam int PT = 16;
    localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [127:0] req_key, req_block;
    logic         req_encdec, req_new_key;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_error, busy, cs, we;
    logic [7:0]   address;
    logic [31:0]  write_data, read_data;

    always #5 clk = ~clk;

    aes_host_ctrl #(.POLL_TIMEOUT(PT), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_block(req_block),
        .req_encdec(req_encdec), .req_new_key(req_new_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
        .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Stand-in cipher: real FIPS-197 pair, otherwise an invertible toy transform.
    function automatic logic [127:0] mock(input logic [127:0] k,
                                          input logic [127:0] b,
                                          input logic e);
        if (k == FK && e && b == FPT) return FCT;
        if (k == FK && !e && b == FCT) return FPT;
        return e ? ((b ^ k) + 128'd1) : ((b - 128'd1) ^ k);
    endfunction

    // ---------------- register slave ----------------
    logic [31:0]  sreg [64];
    int           icnt, ncnt;
    int           idelay = 0, ndelay = 0;
    bit           stuck = 1'b0;
    logic [127:0] sres;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) sreg[i] <= 32'd0;
            icnt <= 0;
            ncnt <= 0;
        end else if (cs && we) begin
            sreg[address[5:0]] <= write_data;
            if (address == 8'h08 && write_data[0]) icnt <= idelay;
            if (address == 8'h08 && write_data[1]) begin
                ncnt <= ndelay;
                sres = mock({sreg[6'h13], sreg[6'h12], sreg[6'h11], sreg[6'h10]},
                            {sreg[6'h23], sreg[6'h22], sreg[6'h21], sreg[6'h20]},
                            sreg[6'h0a][0]);
                for (int i = 0; i < 4; i++) sreg[6'h30 + i] <= sres[32*i +: 32];
            end
        end else if (cs && address == 8'h09) begin
            if (icnt > 0) icnt <= icnt - 1;
            if (ncnt > 0) ncnt <= ncnt - 1;
        end
    end

    always_comb begin
        read_data = 32'd0;
        if (cs && !we) begin
            if (address == 8'h09)
                read_data = stuck ? 32'd0 : {30'd0, ncnt == 0, icnt == 0};
            else
                read_data = sreg[address[5:0]];
        end
    end

    // ---------------- model state ----------------
    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic        first;
    } acc_t;

    acc_t         tr[$];
    acc_t         exq[$];
    acc_t         ma;
    bit           prev_cs = 1'b0;
    bit           in_txn = 1'b0;
    bit           m_cached = 1'b0;
    logic [127:0] m_key = '0;
    logic [127:0] exp_data = '0;
    logic         exp_err = 1'b0;

    function automatic void push(input bit w, input logic [7:0] a,
                                 input logic [31:0] d, input logic [31:0] m,
                                 input bit f);
        acc_t x;
        x.we = w; x.addr = a; x.data = d; x.mask = m; x.first = f;
        exq.push_back(x);
    endfunction

    // bus monitor and per-cycle compare
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            if (cs) begin
                ma.we    = we;
                ma.addr  = address;
                ma.data  = we ? write_data : read_data;
                ma.mask  = '1;
                ma.first = !prev_cs;
                tr.push_back(ma);
            end
            prev_cs = cs;
            chk({req_ready, busy} == {!in_txn, in_txn}, "handshake",
                128'({req_ready, busy}), 128'({!in_txn, in_txn}));
            if (rsp_valid) begin
                chk(rsp_data == exp_data, "rsp_data_hold", rsp_data, exp_data);
                chk({rsp_error, cs} == {exp_err, 1'b0}, "rsp_err_nobus",
                    128'({rsp_error, cs}), 128'({exp_err, 1'b0}));
            end
            if (!in_txn)
                chk({cs, rsp_valid} == 2'b00, "idle_bus",
                    128'({cs, rsp_valid}), 128'(0));
        end else begin
            prev_cs = 1'b0;
        end
    end

    task automatic build_expect(input logic [127:0] k, input logic [127:0] b,
                                input logic e, input logic nk,
                                output bit kl);
        logic [127:0] r;
        r  = mock(k, b, e);
        kl = nk || !m_cached || (k != m_key);
        exq.delete();
        push(1, 8'h0a, {31'd0, e}, '1, 1);
        if (kl) begin
            for (int i = 0; i < 8; i++)
                push(1, 8'(8'h10 + i), (i < 4) ? k[32*i +: 32] : 32'd0, '1, i == 0);
            push(1, 8'h08, 32'h1, '1, 1);
            if (stuck)
                for (int i = 0; i < PT; i++) push(0, 8'h09, 32'h0, 32'h1, i == 0);
            else
                for (int i = 0; i <= idelay; i++)
                    push(0, 8'h09, {31'd0, i == idelay}, 32'h1, i == 0);
        end
        if (!(kl && stuck)) begin
            for (int i = 0; i < 4; i++)
                push(1, 8'(8'h20 + i), b[32*i +: 32], '1, i == 0);
            push(1, 8'h08, 32'h2, '1, 1);
            if (stuck)
                for (int i = 0; i < PT; i++) push(0, 8'h09, 32'h0, 32'h2, i == 0);
            else begin
                for (int i = 0; i <= ndelay; i++)
                    push(0, 8'h09, {30'd0, i == ndelay, 1'b0}, 32'h2, i == 0);
                for (int i = 0; i < 4; i++)
                    push(0, 8'(8'h30 + i), r[32*i +: 32], '1, i == 0);
            end
        end
        exp_err  = stuck;
        exp_data = stuck ? 128'd0 : r;
    endtask

    task automatic drive_req(input logic [127:0] k, input logic [127:0] b,
                             input logic e, input logic nk, input bit pre);
        @(negedge clk);
        tr.delete();
        req_valid   = 1'b1;
        req_key     = k;
        req_block   = b;
        req_encdec  = e;
        req_new_key = nk;
        @(posedge clk);
        in_txn = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
        req_key     = ~k;
        req_block   = ~b;
        req_encdec  = ~e;
        req_new_key = ~nk;
        rsp_ready   = pre;
    endtask

    task automatic run_txn(input logic [127:0] k, input logic [127:0] b,
                           input logic e, input logic nk,
                           input int hold, input bit pre,
                           output logic [127:0] got, output logic gerr,
                           output int lat);
        bit kl;
        int elat;
        bit ok;
        build_expect(k, b, e, nk, kl);
        drive_req(k, b, e, nk, pre);
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            chk(0, "rsp_timeout", 128'(lat), 128'(300));
            finish_sim();
        end
        got  = rsp_data;
        gerr = rsp_error;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        in_txn = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        elat = exq.size();
        foreach (exq[j]) if (exq[j].first) elat++;
        chk(lat == elat, "latency", 128'(lat), 128'(elat));
        chk(got == exp_data, "result", got, exp_data);
        chk(gerr == exp_err, "error_flag", 128'(gerr), 128'(exp_err));
        chk(tr.size() == exq.size(), "trace_len", 128'(tr.size()), 128'(exq.size()));
        for (int j = 0; j < exq.size() && j < tr.size(); j++) begin
            ok = tr[j].we == exq[j].we && tr[j].addr == exq[j].addr &&
                 tr[j].first == exq[j].first &&
                 ((tr[j].data ^ exq[j].data) & exq[j].mask) == 32'd0;
            chk(ok, $sformatf("bus[%0d]", j),
                128'({tr[j].we, tr[j].addr, tr[j].data & exq[j].mask, tr[j].first}),
                128'({exq[j].we, exq[j].addr, exq[j].data & exq[j].mask, exq[j].first}));
        end
        if (stuck) m_cached = 1'b0;
        else if (kl) begin
            m_cached = 1'b1;
            m_key    = k;
        end
    endtask

    logic [127:0] got, pool [3];
    logic         gerr;
    int           lat, w;

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_key = '0; req_block = '0; req_encdec = 1'b0; req_new_key = 1'b0;
        repeat (3) @(negedge clk);
        chk({cs, we, address, write_data} == '0, "reset_bus",
            128'({cs, we, address, write_data}), 128'(0));
        chk({rsp_valid, rsp_error, busy, req_ready} == 4'b0001, "reset_ctl",
            128'({rsp_valid, rsp_error, busy, req_ready}), 128'(4'b0001));
        chk(rsp_data == '0, "reset_data", rsp_data, 128'(0));
        reset = 1'b0;

        idelay = 2; ndelay = 3;
        run_txn(FK, FPT, 1'b1, 1'b0, 2, 1'b0, got, gerr, lat);
        chk(got == FCT, "fips_enc", got, FCT);
        chk(lat == 34, "fips_lat", 128'(lat), 128'(34));

        idelay = 5; ndelay = 0;
        run_txn(FK, FCT, 1'b0, 1'b0, 0, 1'b0, got, gerr, lat);
        chk(got == FPT, "fips_dec", got, FPT);
        chk(lat == 16, "cached_lat", 128'(lat), 128'(16));

        idelay = 0; ndelay = 0;
        run_txn(FK, FPT, 1'b1, 1'b1, 0, 1'b0, got, gerr, lat);
        chk(lat == 29, "newkey_lat", 128'(lat), 128'(29));

        run_txn(FK, 128'h0123456789abcdeffedcba9876543210, 1'b1, 1'b0, 20, 1'b0,
                got, gerr, lat);
        run_txn(FK, FPT, 1'b1, 1'b0, 0, 1'b1, got, gerr, lat);

        stuck = 1'b1;
        run_txn(FK, FPT, 1'b1, 1'b0, 1, 1'b0, got, gerr, lat);
        chk({gerr, got} == {1'b1, 128'd0}, "timeout_pval", 128'({gerr, got[126:0]}),
            {1'b1, 127'd0});
        chk(lat == 26, "timeout_pval_lat", 128'(lat), 128'(26));
        stuck = 1'b0;
        run_txn(FK, FPT, 1'b1, 1'b0, 0, 1'b0, got, gerr, lat);
        chk(lat == 29, "reload_lat", 128'(lat), 128'(29));

        stuck = 1'b1;
        run_txn(FK, FPT, 1'b1, 1'b1, 0, 1'b0, got, gerr, lat);
        chk(lat == 30, "timeout_pinit_lat", 128'(lat), 128'(30));
        stuck = 1'b0;
        run_txn(FK, FPT, 1'b1, 1'b0, 0, 1'b0, got, gerr, lat);

        // reset while block words are being written
        drive_req(FK, FPT, 1'b1, 1'b0, 1'b0);
        w = 0;
        while (!(cs && we && address == 8'h21) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(w < 100, "reach_blk", 128'(w), 128'(100));
        reset  = 1'b1;
        in_txn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({cs, busy, req_ready} == 3'b001, "mid_reset",
            128'({cs, busy, req_ready}), 128'(3'b001));
        reset    = 1'b0;
        m_cached = 1'b0;
        run_txn(FK, FPT, 1'b1, 1'b0, 0, 1'b0, got, gerr, lat);
        chk(got == FCT, "post_reset_enc", got, FCT);

        pool[0] = FK;
        pool[1] = {$urandom, $urandom, $urandom, $urandom};
        pool[2] = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < 40; t++) begin
            idelay = $urandom_range(0, 10);
            ndelay = $urandom_range(0, 10);
            stuck  = ($urandom_range(0, 9) == 0);
            run_txn(pool[$urandom_range(0, 2)],
                    {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3), 1'b0, got, gerr, lat);
        end
        stuck = 1'b0;
        for (int t = 0; t < 4; t++)
            run_txn(pool[1], {$urandom, $urandom, $urandom, $urandom}, 1'b1,
                    1'b0, 0, 1'b1, got, gerr, lat);
        finish_sim();
    end

endmodule
